// File: rtl/kc705_ethernet_rgmii_axi_tx_encoder_pkg.sv
// Shared Ethernet framing constants, state encoding and byte-select helpers
// for the KC705 RGMII AXI TX encoder and RX decoder.
package kc705_ethernet_rgmii_axi_tx_encoder_pkg;

    localparam int unsigned MAC_LEN        = 6;
    localparam int unsigned HDR_LEN        = 2 * MAC_LEN;
    localparam int unsigned HDR_W          = 8 * HDR_LEN;
    localparam int unsigned SIZE_FIELD_LEN = 2;
    localparam int unsigned CTR_FIELD_LEN  = 2;
    localparam int unsigned BYTE_CNT_W     = 16;
    localparam int unsigned FRAME_CNT_W    = 16;

    localparam logic [47:0] DEFAULT_DEST_ADDR = 48'h5a0102030405;
    localparam logic [47:0] DEFAULT_SRC_ADDR  = 48'hda0102030405;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SIZE,
        ST_COUNTER,
        ST_DATA,
        ST_PAD,
        ST_DRAIN,
        ST_OVERHEAD
    } eth_state_e;

    // Header byte idx of {dest, src}, most significant byte first.
    function automatic logic [7:0] hdr_byte(input logic [HDR_W-1:0] hdr,
                                            input logic [BYTE_CNT_W-1:0] idx);
        return 8'(hdr >> (8 * (HDR_LEN - 1 - 32'(idx))));
    endfunction

    // Byte of a 16-bit field, shift_bytes bytes up from the LSB.
    function automatic logic [7:0] field_byte(input logic [15:0] val,
                                              input int unsigned shift_bytes);
        return 8'(val >> (8 * shift_bytes));
    endfunction

endpackage

// File: rtl/kc705_ethernet_rgmii_axi_tx_encoder.sv
// Wraps an AXI-stream payload into an Ethernet frame: MACs, size, frame counter,
// payload padded or truncated to PAYLOAD_LEN, then an idle gap.
module kc705_ethernet_rgmii_axi_tx_encoder
    import kc705_ethernet_rgmii_axi_tx_encoder_pkg::*;
#(
    parameter logic [47:0] DEST_ADDR    = DEFAULT_DEST_ADDR,
    parameter logic [47:0] SRC_ADDR     = DEFAULT_SRC_ADDR,
    parameter logic [15:0] PAYLOAD_LEN  = 16'd32,
    parameter int unsigned PKT_SIZE_LEN = SIZE_FIELD_LEN,
    parameter int unsigned PKT_CTR_LEN  = CTR_FIELD_LEN,
    parameter int unsigned OVERHEAD_LEN = 24
) (
    input  logic        axi_tclk,
    input  logic        axi_treset,
    input  logic        enable_tx_encode,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    output logic        tx_axis_tlast,
    input  logic        tx_axis_tready,
    output logic [15:0] pkt_counter,
    output logic        short_pkt,
    output logic        long_pkt
);

    localparam logic [HDR_W-1:0] HDR      = {DEST_ADDR, SRC_ADDR};
    localparam logic [15:0]      SIZE_VAL = PAYLOAD_LEN + 16'(PKT_CTR_LEN);

    eth_state_e              state_q, state_d;
    logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    tx_last_q, tx_last_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [FRAME_CNT_W-1:0]  pkt_counter_q, pkt_counter_d;
    logic                    short_q, short_d;
    logic                    long_q, long_d;
    logic                    src_done_q, src_done_d;

    logic                    out_acc, out_free, last_acc;
    logic                    s_ready, in_acc, in_last;
    logic [BYTE_CNT_W-1:0]   cnt_inc;

    always_comb begin
        out_acc  = tx_valid_q & tx_axis_tready;
        out_free = ~tx_valid_q | tx_axis_tready;
        last_acc = out_acc & tx_last_q;
        cnt_inc  = cnt_q + 16'd1;

        s_ready = 1'b0;
        if (state_q == ST_DATA) begin
            s_ready = out_free & (cnt_q < PAYLOAD_LEN);
        end else if (state_q == ST_DRAIN) begin
            s_ready = 1'b1;
        end
        in_acc  = s_axis_tvalid & s_ready;
        in_last = in_acc & s_axis_tlast;

        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q & ~tx_axis_tready;
        tx_last_d     = tx_last_q & ~tx_axis_tready;
        frame_cnt_d   = frame_cnt_q + {15'd0, last_acc};
        pkt_counter_d = pkt_counter_q;
        short_d       = 1'b0;
        long_d        = 1'b0;
        src_done_d    = src_done_q;

        case (state_q)
            ST_IDLE: begin
                // Enable only matters here, so dropping it mid-frame is harmless.
                if (enable_tx_encode && s_axis_tvalid) begin
                    state_d       = ST_HEADER;
                    cnt_d         = '0;
                    tx_data_d     = hdr_byte(HDR, 16'd0);
                    tx_valid_d    = 1'b1;
                    tx_last_d     = 1'b0;
                    pkt_counter_d = frame_cnt_q;
                    src_done_d    = 1'b0;
                end
            end
            ST_HEADER: begin
                if (out_acc) begin
                    tx_valid_d = 1'b1;
                    if (cnt_q == 16'(HDR_LEN - 1)) begin
                        state_d   = ST_SIZE;
                        cnt_d     = '0;
                        tx_data_d = field_byte(SIZE_VAL, PKT_SIZE_LEN - 1);
                    end else begin
                        cnt_d     = cnt_inc;
                        tx_data_d = hdr_byte(HDR, cnt_inc);
                    end
                end
            end
            ST_SIZE: begin
                if (out_acc) begin
                    tx_valid_d = 1'b1;
                    if (cnt_q == 16'(PKT_SIZE_LEN - 1)) begin
                        state_d   = ST_COUNTER;
                        cnt_d     = '0;
                        tx_data_d = field_byte(pkt_counter_q, 0);
                    end else begin
                        cnt_d     = cnt_inc;
                        tx_data_d = field_byte(SIZE_VAL, PKT_SIZE_LEN - 1 - 32'(cnt_inc));
                    end
                end
            end
            ST_COUNTER: begin
                if (out_acc) begin
                    if (cnt_q == 16'(PKT_CTR_LEN - 1)) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        tx_valid_d = 1'b1;
                        cnt_d      = cnt_inc;
                        tx_data_d  = field_byte(pkt_counter_q, 32'(cnt_inc));
                    end
                end
            end
            ST_DATA: begin
                if (in_acc) begin
                    tx_data_d  = s_axis_tdata;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (cnt_inc == PAYLOAD_LEN);
                    cnt_d      = cnt_inc;
                    if (s_axis_tlast && (cnt_inc < PAYLOAD_LEN)) begin
                        state_d = ST_PAD;
                        short_d = 1'b1;
                    end else if (!s_axis_tlast && (cnt_inc == PAYLOAD_LEN)) begin
                        state_d = ST_DRAIN;
                        long_d  = 1'b1;
                    end
                end else if (last_acc) begin
                    state_d = ST_OVERHEAD;
                    cnt_d   = '0;
                end
            end
            ST_PAD: begin
                if (last_acc) begin
                    state_d = ST_OVERHEAD;
                    cnt_d   = '0;
                end else if (out_free && (cnt_q < PAYLOAD_LEN)) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (cnt_inc == PAYLOAD_LEN);
                    cnt_d      = cnt_inc;
                end
            end
            ST_DRAIN: begin
                // Leave only once the source frame ended and the final byte has gone.
                src_done_d = src_done_q | in_last;
                if ((src_done_q || in_last) && out_free) begin
                    state_d = ST_OVERHEAD;
                    cnt_d   = '0;
                end
            end
            ST_OVERHEAD: begin
                if (cnt_q == 16'(OVERHEAD_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_tclk) begin
        if (axi_treset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            frame_cnt_q   <= '0;
            pkt_counter_q <= '0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            src_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_last_q     <= tx_last_d;
            frame_cnt_q   <= frame_cnt_d;
            pkt_counter_q <= pkt_counter_d;
            short_q       <= short_d;
            long_q        <= long_d;
            src_done_q    <= src_done_d;
        end
    end

    assign s_axis_tready  = s_ready;
    assign tx_axis_tdata  = tx_data_q;
    assign tx_axis_tvalid = tx_valid_q;
    assign tx_axis_tlast  = tx_last_q;
    assign pkt_counter    = pkt_counter_q;
    assign short_pkt      = short_q;
    assign long_pkt       = long_q;

endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_tx_encoder.sv
// Frame-level model of the TX encoder compared beat by beat against the DUT.
module tb_kc705_ethernet_rgmii_axi_tx_encoder;

    localparam int P   = 32;
    localparam int OVH = 24;
    localparam logic [47:0] DEST = 48'h5a0102030405;
    localparam logic [47:0] SRC  = 48'hda0102030405;

    logic        clk = 1'b0;
    logic        axi_treset;
    logic        enable_tx_encode;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [15:0] pkt_counter;
    logic        short_pkt;
    logic        long_pkt;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    int model_ctr = 0;
    int exp_short = 0;
    int exp_long = 0;
    int short_seen = 0;
    int long_seen = 0;
    bit tr_toggle = 1'b0;

    always #5 clk = ~clk;

    kc705_ethernet_rgmii_axi_tx_encoder dut (
        .axi_tclk        (clk),
        .axi_treset      (axi_treset),
        .enable_tx_encode(enable_tx_encode),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .tx_axis_tdata   (tx_data),
        .tx_axis_tvalid  (tx_valid),
        .tx_axis_tlast   (tx_last),
        .tx_axis_tready  (tx_ready),
        .pkt_counter     (pkt_counter),
        .short_pkt       (short_pkt),
        .long_pkt        (long_pkt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected wire image of one frame whose source delivers n bytes from base.
    task automatic model_frame(input int base, input int n);
        logic [15:0] sz;
        logic [15:0] ctr;
        sz  = 16'(P + 2);
        ctr = 16'(model_ctr);
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'(DEST >> (8 * (5 - i)))});
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'(SRC >> (8 * (5 - i)))});
        exp_q.push_back({1'b0, sz[15:8]});
        exp_q.push_back({1'b0, sz[7:0]});
        exp_q.push_back({1'b0, ctr[7:0]});
        exp_q.push_back({1'b0, ctr[15:8]});
        for (int i = 0; i < P; i++) exp_q.push_back({(i == P - 1), (i < n) ? 8'(base + i) : 8'h00});
        model_ctr = (model_ctr + 1) % 65536;
        if (n < P) exp_short++;
        if (n > P) exp_long++;
    endtask

    task automatic src_send(input int base, input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            s_tdata  = 8'(base + i);
            s_tvalid = 1'b1;
            s_tlast  = with_last && (i == n - 1);
            @(negedge clk);
            while (!s_tready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                checks++;
                errors++;
                $display("FAIL src_ready_timeout: byte %0d never accepted", i);
                break;
            end
            @(posedge clk); #1;
            if (gaps && (i % 4 == 1)) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (OVH + 4) @(posedge clk);
        #1;
        chk("drain_remaining", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, tx_valid}, 0);
        chk({tag, "_tlast"}, {31'd0, tx_last}, 0);
        chk({tag, "_tdata"}, {24'd0, tx_data}, 0);
        chk({tag, "_s_tready"}, {31'd0, s_tready}, 0);
        chk({tag, "_pkt_counter"}, {16'd0, pkt_counter}, 0);
        chk({tag, "_short"}, {31'd0, short_pkt}, 0);
        chk({tag, "_long"}, {31'd0, long_pkt}, 0);
    endtask

    initial begin : ready_driver
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = tr_toggle ? ~tx_ready : 1'b1;
        end
    end

    initial begin : compare
        logic       stall_prev;
        logic [7:0] d_prev;
        logic       l_prev;
        bit         after_last;
        int         idle_run;
        logic [8:0] e;
        stall_prev = 1'b0;
        d_prev     = 8'h00;
        l_prev     = 1'b0;
        after_last = 1'b0;
        idle_run   = 0;
        forever begin
            @(negedge clk);
            if (axi_treset === 1'b1) begin
                stall_prev = 1'b0;
                after_last = 1'b0;
                idle_run   = 0;
                continue;
            end
            if (short_pkt) short_seen++;
            if (long_pkt) long_seen++;
            if (stall_prev) begin
                chk("hold_tvalid", {31'd0, tx_valid}, 1);
                chk("hold_tdata", {24'd0, tx_data}, {24'd0, d_prev});
                chk("hold_tlast", {31'd0, tx_last}, {31'd0, l_prev});
            end
            if (tx_valid) begin
                if (after_last) begin
                    chk("overhead_gap_ge_24", 32'(idle_run >= OVH), 1);
                    after_last = 1'b0;
                end
            end else if (after_last) begin
                idle_run++;
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h last %0b, expected no beat", tx_data, tx_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", {24'd0, tx_data}, {24'd0, e[7:0]});
                    chk("tlast", {31'd0, tx_last}, {31'd0, e[8]});
                end
                if (tx_last) begin
                    after_last = 1'b1;
                    idle_run   = 0;
                end
            end
            stall_prev = tx_valid && !tx_ready;
            d_prev     = tx_data;
            l_prev     = tx_last;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        axi_treset       = 1'b1;
        enable_tx_encode = 1'b1;
        s_tdata          = 8'h00;
        s_tvalid         = 1'b0;
        s_tlast          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        axi_treset = 1'b0;

        // Nominal frame 0x00..0x1F; pin the model to the literal wire image.
        model_frame(0, 32);
        chk("model_byte0", 32'(exp_q[0]), 32'h05a);
        chk("model_byte5", 32'(exp_q[5]), 32'h005);
        chk("model_byte6", 32'(exp_q[6]), 32'h0da);
        chk("model_size_hi", 32'(exp_q[12]), 32'h000);
        chk("model_size_lo", 32'(exp_q[13]), 32'h022);
        chk("model_ctr_lo", 32'(exp_q[14]), 32'h000);
        chk("model_pay1", 32'(exp_q[17]), 32'h001);
        chk("model_last", 32'(exp_q[47]), 32'h11f);
        chk("model_len", 32'(exp_q.size()), 48);
        src_send(0, 32, 1'b1, 1'b0);

        model_frame(64, 32);
        src_send(64, 32, 1'b1, 1'b0);
        model_frame(128, 32);
        src_send(128, 32, 1'b1, 1'b0);
        wait_drain();
        chk("pkt_counter_after_three", {16'd0, pkt_counter}, 2);

        // Short source frame: 20 bytes then 12 zero pad bytes.
        model_frame(160, 20);
        src_send(160, 20, 1'b1, 1'b0);
        wait_drain();
        chk("short_pkt_pulses", 32'(short_seen), 32'(exp_short));

        // Long source frame, then a stalling source on the next frame.
        model_frame(200, 40);
        src_send(200, 40, 1'b1, 1'b0);
        model_frame(10, 32);
        src_send(10, 32, 1'b1, 1'b1);
        wait_drain();
        chk("long_pkt_pulses", 32'(long_seen), 32'(exp_long));

        // Backpressure alternating every cycle.
        tr_toggle = 1'b1;
        model_frame(50, 32);
        src_send(50, 32, 1'b1, 1'b0);
        wait_drain();
        tr_toggle = 1'b0;
        @(posedge clk); #1;
        chk("pkt_counter_after_toggle", {16'd0, pkt_counter}, 6);

        // Reset at payload byte 10 abandons the frame and restarts counting.
        model_frame(90, 32);
        src_send(90, 10, 1'b0, 1'b0);
        axi_treset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk_reset_outputs("midreset");
        axi_treset = 1'b0;
        model_ctr  = 0;
        model_frame(120, 32);
        src_send(120, 32, 1'b1, 1'b0);
        wait_drain();
        chk("pkt_counter_after_reset", {16'd0, pkt_counter}, 0);
        chk("short_pkt_total", 32'(short_seen), 1);
        chk("long_pkt_total", 32'(long_seen), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kc705_ethernet_rgmii_axi_tx_encoder.md
KC705_ETHERNET_RGMII_AXI_TX_ENCODER -- requirements
Module: kc705_ethernet_rgmii_axi_tx_encoder

Interface
REQ-001 Param DEST_ADDR, 48'h5a0102030405, destination MAC inserted in every frame.
REQ-002 Param SRC_ADDR, 48'hda0102030405, source MAC inserted in every frame.
REQ-003 Param PAYLOAD_LEN, 16'd32, payload bytes per frame (register-map response length).
REQ-004 Param PKT_SIZE_LEN, 2, size-field bytes; PKT_CTR_LEN, 2, counter-field bytes; OVERHEAD_LEN, 24, idle cycles between frames.
REQ-005 One clock; reset is synchronous and active-high: axi_tclk input 1, clock; axi_treset input 1, synchronous active-high reset.
REQ-006 enable_tx_encode  input  1  permits start of a new frame.
REQ-007 s_axis_tdata/tvalid/tlast  input  8/1/1  payload byte stream; s_axis_tready  output  1.
REQ-008 tx_axis_tdata/tvalid/tlast  output  8/1/1  framed Ethernet byte stream; tx_axis_tready  input  1.
REQ-009 pkt_counter  output  16  value inserted in the most recent frame.
REQ-010 short_pkt, long_pkt  output  1 each  one-cycle error pulses.

Function
REQ-011 States: IDLE, HEADER, SIZE, COUNTER, DATA, PAD, DRAIN, OVERHEAD.
REQ-012 IDLE->HEADER when enable_tx_encode=1 and s_axis_tvalid=1; enable is sampled only in IDLE, so deassertion mid-frame does not truncate the frame.
REQ-013 Frame byte order: DEST_ADDR MSB first (6), SRC_ADDR MSB first (6), size field MSB first, counter field LSB first, then payload.
REQ-014 Size field value = PAYLOAD_LEN + PKT_CTR_LEN (default 16'h0022).
REQ-015 Every output byte advances only on tx_axis_tvalid & tx_axis_tready; HEADER/SIZE/COUNTER each exit after their last byte is accepted.
REQ-016 tx_axis_tdata/tvalid/tlast are registered; once tvalid=1, data and tlast hold stable until tready=1.
REQ-017 First header byte presented with tx_axis_tvalid=1 the cycle after the IDLE->HEADER transition.
REQ-018 s_axis_tready = 1 in DATA when output register is empty or being accepted, and always 1 in DRAIN; 0 in all other states.
REQ-019 DATA: each accepted input byte moves to the output register; tx_axis_tvalid drops while the source stalls (gaps permitted).
REQ-020 tx_axis_tlast=1 exactly on payload byte PAYLOAD_LEN, never on header bytes.
REQ-021 Short payload (s_axis_tlast on byte k < PAYLOAD_LEN): go to PAD, emit PAYLOAD_LEN-k bytes of 8'h00, pulse short_pkt on the cycle s_axis_tlast is accepted.
REQ-022 Long payload (byte PAYLOAD_LEN accepted without s_axis_tlast): go to DRAIN, discard input until s_axis_tlast accepted, pulse long_pkt once on DRAIN entry.
REQ-023 Exact payload: after the tlast byte is accepted downstream, go to OVERHEAD.
REQ-024 OVERHEAD: hold tx_axis_tvalid=0 for OVERHEAD_LEN cycles, then IDLE; DRAIN and PAD exit to OVERHEAD after completion.
REQ-025 Frame counter increments by 1 when a frame's tlast byte is accepted; wraps 16'hFFFF->16'h0000; pkt_counter output updates at frame start.
REQ-026 Byte counters sized 16 bits; no arithmetic overflow for PAYLOAD_LEN up to 1500.

Reset
REQ-027 On axi_treset: state IDLE, tx_axis_tvalid=0, tx_axis_tlast=0, tx_axis_tdata=8'h00, s_axis_tready=0, pkt_counter=0, frame counter=0, short_pkt=long_pkt=0.
REQ-028 Reset mid-frame abandons the frame without emitting tlast; the next frame starts with counter 0.

Structure
REQ-029 State encoding, header/size/counter lengths and default MAC constants live in the shared ethernet package also used by the RX decoder.
REQ-030 Single module; no sub-modules required.

Verification
REQ-031 32 payload bytes 0x00..0x1F, tready=1 -> 48 output bytes: 5a 01 02 03 04 05 da 01 02 03 04 05 00 22 00 00 00..1F, tlast on byte 48, then 24 idle cycles.
REQ-032 Three back-to-back frames -> counter bytes 00 00, 01 00, 02 00; pkt_counter ends at 2.
REQ-033 Source tlast on byte 20 -> 12 bytes 0x00 padding, tlast on payload byte 32, short_pkt pulses once.
REQ-034 40-byte source frame -> bytes 33..40 consumed, not emitted; long_pkt pulses once; next frame aligned.
REQ-035 tready toggles 1/0 every cycle during header -> each byte held until accepted, sequence unchanged.
REQ-036 axi_treset asserted at payload byte 10 -> all outputs at reset values next cycle; following frame carries counter 00 00.
